stack_unit: RTL and testbench
=============================

# stack_unit

Hardware operand stack for the 8-bit stack-machine datapath. Sits directly upstream of the ALU and data-memory path inside `top`: the decoder drives one stack operation per cycle, and the unit presents top-of-stack (TOS) and next-on-stack (NOS) as ALU operands. It accepts results back as pushes or as a binary-op replace. Overflow, underflow and illegal opcodes are detected, suppressed and latched so the program can be halted with a diagnosable error.

## Interface
- `DW`, 8, data width of each stack entry
- `DEPTH`, 16, number of stack entries
- `SPW`, 5, width of `depth` output; must hold 0..`DEPTH`
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `op`  in  3  stack command:
  - 000 NOP
  - 001 PUSH
  - 010 POP
  - 011 DUP
  - 100 SWAP
  - 101 REPL (pop two, push `din`)
  - 110, 111 reserved
- `din`  in  `DW`  data for PUSH and REPL
- `tos`  out  `DW`  entry at `depth-1`; 0 when `depth==0`
- `nos`  out  `DW`  entry at `depth-2`; 0 when `depth<2`
- `depth`  out  `SPW`  current entry count
- `empty`  out  1  `depth==0`
- `full`  out  1  `depth==DEPTH`
- `err`  out  1  sticky error flag
- `err_code`  out  2  first error cause: 00 none, 01 overflow, 10 underflow, 11 illegal op

## Operation
- Storage is a `DEPTH`×`DW` register array plus a `depth` counter. Entry 0 is the bottom of the stack.
- Each op has a legality condition. A legal op updates the stack as follows:
  - PUSH: requires `depth<DEPTH`. `mem[depth]=din`, `depth+1`.
  - POP: requires `depth>=1`. `depth-1`. The vacated entry is not cleared.
  - DUP: requires `1<=depth<DEPTH`. `mem[depth]=mem[depth-1]`, `depth+1`.
  - SWAP: requires `depth>=2`. Exchanges `mem[depth-1]` and `mem[depth-2]` in the same edge. `depth` is unchanged.
  - REPL: requires `depth>=2`. `mem[depth-2]=din`, `depth-1`.
- Illegal ops:
  - An op that fails its legality condition is suppressed: no array write and no `depth` change.
  - Classification: PUSH on full, or DUP on full, is overflow (01). POP/DUP/SWAP/REPL with insufficient entries is underflow (10).
  - Ops 110 and 111 are illegal (11). No stack change.
  - DUP with `depth==0` is underflow, never overflow. With `DEPTH>=1`, a DUP cannot be both empty and full.
- On any suppressed op, `err` is set. `err_code` loads the cause only if `err` was 0, so the first cause is kept.
- Both flags hold until `reset`. Later legal ops still execute normally while `err` is set.
- `depth` never wraps: it is bounded to 0..`DEPTH` by construction.

## Timing
- Every op is single-cycle. The command is sampled on the rising edge, and the new `tos`, `nos`, `depth`, `empty` and `full` are valid immediately after that edge.
- `tos`, `nos`, `empty` and `full` are combinational decodes of registered state. There is no input-to-output combinational path from `op` or `din`.
- Back-to-back ops are allowed every cycle with no stalls. For example, PUSH then POP leaves `depth` unchanged after 2 edges.
- REPL supports the ALU loop: the ALU reads `tos`/`nos` in cycle N, and the decoder issues REPL with the result in the same cycle N. The result is visible as `tos` in cycle N+1.
- Reset:
  - On `reset=1` at an edge: `depth=0`, `err=0`, `err_code=00`. Therefore `tos=0`, `nos=0`, `empty=1`, `full=0`.
  - Array contents need not be cleared.
  - Reset overrides any concurrent `op`, including mid-sequence.

## Test plan
- Reset, then PUSH 0x4d, PUSH 0x72 → `depth=2`, `tos=0x72`, `nos=0x4d`, `empty=0`, `err=0`.
- From that state:
  - SWAP → `tos=0x4d`, `nos=0x72`.
  - DUP → `depth=3`, `tos=nos=0x4d`.
  - REPL with `din=0xbf` → `depth=2`, `tos=0xbf`, `nos=0x72`.
- Fill with 16 PUSHes of 0x00..0x0f → `full=1`, `tos=0x0f`. A 17th PUSH of 0xaa → `depth=16`, `tos=0x0f`, `err=1`, `err_code=01`. A following POP still works: `depth=15`, `tos=0x0e`.
- After reset, POP on empty → `depth=0`, `err=1`, `err_code=10`. A subsequent SWAP with `depth=1` keeps `err_code=10` (first error held).
- Op 111 with `depth=3` → stack unchanged, `err_code=11`. Assert `reset` in the same cycle as a PUSH → `depth=0`, `err=0` after the edge.
- Random mix of 2000 ops against a queue-based reference model → `tos`, `nos`, `depth`, `err` and `err_code` match every cycle.

Source files
------------

// File: rtl/stack_unit.sv
// Operand stack feeding the ALU. It supplies TOS and NOS, accepts one command per cycle,
// and blocks any command that would overflow or underflow, latching the first fault cause.
module stack_unit #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int SPW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      op,
  input  logic [DW-1:0]   din,
  output logic [DW-1:0]   tos,
  output logic [DW-1:0]   nos,
  output logic [SPW-1:0]  depth,
  output logic            empty,
  output logic            full,
  output logic            err,
  output logic [1:0]      err_code
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] FULL_DEPTH = SPW'(DEPTH);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_PUSH = 3'b001,
    OP_POP  = 3'b010,
    OP_DUP  = 3'b011,
    OP_SWAP = 3'b100,
    OP_REPL = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_OVER  = 2'b01,
    ERR_UNDER = 2'b10,
    ERR_ILLOP = 2'b11
  } err_e;

  logic [DW-1:0]  mem [DEPTH];
  logic [AW-1:0]  push_idx, top_idx, sec_idx;
  logic           has_two;

  logic           we_a, we_b;
  logic [AW-1:0]  idx_a, idx_b;
  logic [DW-1:0]  dat_a, dat_b;
  logic [SPW-1:0] depth_nxt;
  logic           fault;
  logic [1:0]     fault_code;

  // Slot indices use modular low bits, so depth == DEPTH wraps push_idx to 0.
  // Every read or write that uses these indices is guarded by the empty, full and has_two checks.
  assign push_idx = depth[AW-1:0];
  assign top_idx  = depth[AW-1:0] - AW'(1);
  assign sec_idx  = depth[AW-1:0] - AW'(2);

  assign empty   = (depth == '0);
  assign full    = (depth == FULL_DEPTH);
  assign has_two = (depth >= SPW'(2));

  assign tos = empty   ? '0 : mem[top_idx];
  assign nos = has_two ? mem[sec_idx] : '0;

  always_comb begin
    depth_nxt  = depth;
    we_a       = 1'b0;
    idx_a      = push_idx;
    dat_a      = din;
    we_b       = 1'b0;
    idx_b      = sec_idx;
    dat_b      = tos;
    fault      = 1'b0;
    fault_code = ERR_NONE;
    case (op)
      OP_NOP: begin
      end
      OP_PUSH: begin
        if (!full) begin
          we_a      = 1'b1;
          depth_nxt = depth + SPW'(1);
        end else begin
          fault      = 1'b1;
          fault_code = ERR_OVER;
        end
      end
      OP_POP: begin
        if (!empty) begin
          depth_nxt = depth - SPW'(1);
        end else begin
          fault      = 1'b1;
          fault_code = ERR_UNDER;
        end
      end
      OP_DUP: begin
        // Check empty first so that a DUP on an empty stack is always reported as underflow.
        if (empty) begin
          fault      = 1'b1;
          fault_code = ERR_UNDER;
        end else if (full) begin
          fault      = 1'b1;
          fault_code = ERR_OVER;
        end else begin
          we_a      = 1'b1;
          dat_a     = mem[top_idx];
          depth_nxt = depth + SPW'(1);
        end
      end
      OP_SWAP: begin
        if (has_two) begin
          we_a  = 1'b1;
          idx_a = top_idx;
          dat_a = mem[sec_idx];
          we_b  = 1'b1;
          idx_b = sec_idx;
          dat_b = mem[top_idx];
        end else begin
          fault      = 1'b1;
          fault_code = ERR_UNDER;
        end
      end
      OP_REPL: begin
        if (has_two) begin
          we_a      = 1'b1;
          idx_a     = sec_idx;
          depth_nxt = depth - SPW'(1);
        end else begin
          fault      = 1'b1;
          fault_code = ERR_UNDER;
        end
      end
      default: begin
        fault      = 1'b1;
        fault_code = ERR_ILLOP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth    <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      depth <= depth_nxt;
      if (fault) begin
        err <= 1'b1;
        if (!err) err_code <= fault_code;
      end
    end
  end

  // The array has no reset. Gating the write on reset keeps a PUSH issued during reset from landing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (we_a) mem[idx_a] <= dat_a;
      if (we_b) mem[idx_b] <= dat_b;
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: a queue-based stack model predicts each cycle's outputs,
// and a separate monitor compares them against the DUT one step after each rising edge.
module tb_stack_unit;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int SPW   = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic [2:0]     op;
  logic [DW-1:0]  din;
  logic [DW-1:0]  tos, nos;
  logic [SPW-1:0] depth;
  logic           empty, full, err;
  logic [1:0]     err_code;

  stack_unit #(.DW(DW), .DEPTH(DEPTH), .SPW(SPW)) dut (
    .clk(clk), .reset(reset), .op(op), .din(din),
    .tos(tos), .nos(nos), .depth(depth), .empty(empty), .full(full),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] tos;
    logic [DW-1:0] nos;
    int            depth;
    logic          empty;
    logic          full;
    logic          err;
    logic [1:0]    code;
  } exp_t;

  exp_t          scb[$];
  logic [DW-1:0] mstack[$];
  logic          merr;
  logic [1:0]    mcode;
  int            checks = 0;
  int            errors = 0;

  // The model works directly on the stack queue; its back element is the top of the stack.
  task automatic modelStep(input logic [2:0] o, input logic [DW-1:0] d, input logic r);
    logic       f;
    logic [1:0] c;
    logic [DW-1:0] a, b;
    f = 1'b0;
    c = 2'b00;
    if (r) begin
      mstack.delete();
      merr  = 1'b0;
      mcode = 2'b00;
      return;
    end
    case (o)
      3'd0: ;
      3'd1: if (mstack.size() < DEPTH) mstack.push_back(d); else begin f = 1'b1; c = 2'b01; end
      3'd2: if (mstack.size() >= 1) a = mstack.pop_back(); else begin f = 1'b1; c = 2'b10; end
      3'd3: begin
        if (mstack.size() == 0) begin f = 1'b1; c = 2'b10; end
        else if (mstack.size() == DEPTH) begin f = 1'b1; c = 2'b01; end
        else begin a = mstack[$]; mstack.push_back(a); end
      end
      3'd4: begin
        if (mstack.size() >= 2) begin
          a = mstack.pop_back();
          b = mstack.pop_back();
          mstack.push_back(a);
          mstack.push_back(b);
        end else begin f = 1'b1; c = 2'b10; end
      end
      3'd5: begin
        if (mstack.size() >= 2) begin
          a = mstack.pop_back();
          b = mstack.pop_back();
          mstack.push_back(d);
        end else begin f = 1'b1; c = 2'b10; end
      end
      default: begin f = 1'b1; c = 2'b11; end
    endcase
    if (f) begin
      if (!merr) mcode = c;
      merr = 1'b1;
    end
  endtask

  function automatic exp_t modelView();
    exp_t e;
    int n;
    n       = mstack.size();
    e.depth = n;
    e.tos   = (n >= 1) ? mstack[n-1] : '0;
    e.nos   = (n >= 2) ? mstack[n-2] : '0;
    e.empty = (n == 0);
    e.full  = (n == DEPTH);
    e.err   = merr;
    e.code  = mcode;
    return e;
  endfunction

  task automatic applyStimulus(input logic [2:0] o, input logic [DW-1:0] d, input logic r);
    @(negedge clk);
    op    = o;
    din   = d;
    reset = r;
    modelStep(o, d, r);
    scb.push_back(modelView());
  endtask

  task automatic cmpField(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmpField("tos",      int'(tos),      int'(e.tos));
    cmpField("nos",      int'(nos),      int'(e.nos));
    cmpField("depth",    int'(depth),    e.depth);
    cmpField("empty",    int'(empty),    int'(e.empty));
    cmpField("full",     int'(full),     int'(e.full));
    cmpField("err",      int'(err),      int'(e.err));
    cmpField("err_code", int'(err_code), int'(e.code));
  endtask

  // The monitor takes one expected snapshot per edge once stimulus has queued it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (scb.size() > 0) checkOutput(scb.pop_front());
    end
  end

  initial begin
    logic [2:0] ro;
    int         waited;
    reset = 1'b1;
    op    = 3'd0;
    din   = '0;
    merr  = 1'b0;
    mcode = 2'b00;

    applyStimulus(3'd0, 8'h00, 1'b1);
    applyStimulus(3'd1, 8'h4d, 1'b0);
    applyStimulus(3'd1, 8'h72, 1'b0);
    applyStimulus(3'd4, 8'h00, 1'b0);
    applyStimulus(3'd4, 8'h00, 1'b0);
    applyStimulus(3'd3, 8'h00, 1'b0);
    applyStimulus(3'd2, 8'h00, 1'b0);
    applyStimulus(3'd5, 8'hbf, 1'b0);

    applyStimulus(3'd0, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(3'd1, 8'(i), 1'b0);
    applyStimulus(3'd1, 8'haa, 1'b0);
    applyStimulus(3'd3, 8'h00, 1'b0);
    applyStimulus(3'd2, 8'h00, 1'b0);

    applyStimulus(3'd0, 8'h00, 1'b1);
    applyStimulus(3'd2, 8'h00, 1'b0);
    applyStimulus(3'd1, 8'h11, 1'b0);
    applyStimulus(3'd4, 8'h00, 1'b0);
    applyStimulus(3'd5, 8'h22, 1'b0);

    applyStimulus(3'd0, 8'h00, 1'b1);
    applyStimulus(3'd3, 8'h00, 1'b0);
    applyStimulus(3'd1, 8'h01, 1'b0);
    applyStimulus(3'd1, 8'h02, 1'b0);
    applyStimulus(3'd1, 8'h03, 1'b0);
    applyStimulus(3'd7, 8'h00, 1'b0);
    applyStimulus(3'd2, 8'h00, 1'b0);
    applyStimulus(3'd1, 8'h55, 1'b1);
    applyStimulus(3'd0, 8'h00, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      ro = 3'($urandom_range(0, 7));
      applyStimulus(ro, 8'($urandom), ($urandom_range(0, 63) == 0));
    end

    waited = 0;
    while (scb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    checks++;
    if (scb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain actual=%0d expected=0", scb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
